// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data-memory port.
// It holds a word-organised RAM with byte-lane stores and extended loads, and serves one request at a time.
module data_mem_responder #(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W = $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Reserved funct3 codes, stores using the unsigned load codes, or misaligned H/W accesses.
   function automatic logic is_illegal(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
      logic bad;
      case (f3)
         3'b000:  bad = 1'b0;
         3'b001:  bad = lane[0];
         3'b010:  bad = (lane != 2'b00);
         3'b100:  bad = wr;
         3'b101:  bad = wr | lane[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lane);
      logic [3:0] strb;
      case (f3)
         3'b000:  strb = 4'b0001 << lane;
         3'b001:  strb = lane[1] ? 4'b1100 : 4'b0011;
         3'b010:  strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] d;
      case (f3[1:0])
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b010:  r = word;
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   logic [31:0]           mem [DEPTH];
   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [31:0]           pend_q, pend_d;

   logic                  accept_s;
   logic                  err_s;
   logic                  we_s;
   logic [ADDR_WIDTH-1:0] idx_s;
   logic [1:0]            lane_s;
   logic [3:0]            strb_s;
   logic [31:0]           wdata_s;
   logic [31:0]           load_s;
   logic                  unused_addr_s;

   assign req_ready     = (state_q == ST_IDLE);
   assign accept_s      = req_valid & req_ready;
   assign idx_s         = req_addr[ADDR_WIDTH+1:2];
   assign lane_s        = req_addr[1:0];
   assign unused_addr_s = ^req_addr[31:ADDR_WIDTH+2];
   assign err_s         = is_illegal(req_write, req_funct3, lane_s);
   assign we_s          = accept_s & req_write & ~err_s;
   assign strb_s        = store_strobe(req_funct3, lane_s);
   assign wdata_s       = store_data(req_funct3, req_wdata);
   assign load_s        = load_extract(req_funct3, lane_s, mem[idx_s]);

   assign rsp_valid = valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_error = err_q;

   // RAM byte-lane write on the store accept edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (strb_s[i]) begin
               mem[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
            end
         end
      end
   end

   // Control and response registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         pend_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         pend_q  <= pend_d;
      end
   end

   // Next-state and response decode; load data waits in pend_q while the latency counter runs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      pend_d  = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (err_s) begin
                  state_d = ST_RESP;
                  valid_d = 1'b1;
                  rdata_d = 32'd0;
                  err_d   = 1'b1;
               end else if (req_write) begin
                  state_d = ST_RESP;
                  valid_d = 1'b1;
                  rdata_d = 32'd0;
                  err_d   = 1'b0;
               end else if (READ_LATENCY == 1) begin
                  state_d = ST_RESP;
                  valid_d = 1'b1;
                  rdata_d = load_s;
                  err_d   = 1'b0;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_W'(READ_LATENCY - 1);
                  pend_d  = load_s;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
               cnt_d   = '0;
               valid_d = 1'b1;
               rdata_d = pend_q;
               err_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               rdata_d = 32'd0;
               err_d   = 1'b0;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            rdata_d = 32'd0;
            err_d   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (ADDR_WIDTH=10, READ_LATENCY=2).
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   int checks = 0;
   int errors = 0;
   int lat;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_error  (rsp_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge and hold it until the accepting rising edge.
   task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // lat = 1 means rsp_valid was already high one step after the accept edge.
   task automatic wait_rsp(output int l);
      l = 1;
      while (!rsp_valid && l < 20) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic xact(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err,
                       input int exp_lat);
      int l;
      issue(w, f3, a, d);
      wait_rsp(l);
      chk({tag, "_lat"}, l, exp_lat);
      chk({tag, "_data"}, rsp_rdata, exp_data);
      chk({tag, "_err"}, {31'd0, rsp_error}, {31'd0, exp_err});
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk({tag, "_drop"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      #1;
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_error", {31'd0, rsp_error}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      #20;
      resetn = 1'b1;

      xact("sw_10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
      xact("lw_10",   1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
      xact("sb_13",   1'b1, 3'b000, 32'h13, 32'h80, 32'h0, 1'b0, 1);
      xact("lb_13",   1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
      xact("lbu_13",  1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
      xact("lw_10b",  1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 2);
      xact("sh_12",   1'b1, 3'b001, 32'h12, 32'h1234, 32'h0, 1'b0, 1);
      xact("lh_12",   1'b0, 3'b001, 32'h12, 32'h0, 32'h00001234, 1'b0, 2);
      xact("sh_11",   1'b1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1'b1, 1);
      xact("lw_10c",  1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 2);
      xact("lh_10",   1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
      xact("lhu_10",  1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 2);
      xact("lb_10",   1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2);
      xact("lbu_11",  1'b0, 3'b100, 32'h11, 32'h0, 32'h000000BE, 1'b0, 2);
      xact("lw_12",   1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1);
      xact("lhu_13",  1'b0, 3'b101, 32'h13, 32'h0, 32'h0, 1'b1, 1);
      xact("sbu_10",  1'b1, 3'b100, 32'h10, 32'h11111111, 32'h0, 1'b1, 1);
      xact("f110_10", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1);
      xact("lw_10d",  1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 2);
      xact("sw_1000", 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0, 1);
      xact("lw_0",    1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 2);
      xact("f011_0",  1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1);

      // Back-pressure: response held while a second request waits.
      issue(1'b0, 3'b010, 32'h0, 32'h0);
      wait_rsp(lat);
      chk("bp_lat", lat, 2);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rdata", rsp_rdata, 32'hCAFEF00D);
         chk("bp_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_hs_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("bp2_accepted", {31'd0, req_ready}, 32'd0);
      chk("bp2_not_yet", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("bp2_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp2_rdata", rsp_rdata, 32'h1234BEEF);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;

      // Reset while a load is in flight.
      issue(1'b0, 3'b010, 32'h10, 32'h0);
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_quiet", {31'd0, rsp_valid}, 32'd0);
         chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      end
      xact("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234BEEF, 1'b0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
